// File: rtl/spi_share_pkg.sv
// spi_share_pkg
//   Shared types and constants for the SPI bus-sharing arbiter.
//   owner_t : encoding of the owner output (none / host / SD).
//   state_t : arbiter state machine states.
//   sat_inc : saturating increment for the collision counter.
package spi_share_pkg;

   localparam int COLL_CNT_W = 8;
   localparam int GUARD_W    = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_HOST = 2'd1,
      OWN_SD   = 2'd2
   } owner_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT_HOST = 2'd1,
      GRANT_SD   = 2'd2,
      GUARD      = 2'd3
   } state_t;

   function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/spi_share_arbiter_sync_bit.sv
// sync_bit
//   N-stage flip-flop synchroniser for one asynchronous bit, with a
//   programmable reset value so each chain powers up at its inactive level.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronised output (last stage)
module sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain_q <= {STAGES{RST_VAL}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_share_arbiter.sv
// spi_share_arbiter
//   Arbitrates the shared SPI slave bus between the MCU host channels
//   (data_io ss2_n, OSD ss3_n, user_io conf_data0) and the SD passthrough
//   (ss4_n). Selects and SCKs are synchronised into clk_sys; the bus is
//   granted to one side at a time with a guard interval between owners.
//   Inputs : clk_sys, reset (async, active high), ss2_n, ss3_n, conf_data0,
//            ss4_n, sck_host, sck_sd, miso_core, miso_sd, clr_stats.
//   Outputs: sck_out (gated SCK to core), miso_out/miso_oe (SPI_DO drive),
//            owner (0 none, 1 host, 2 SD), collision (sticky),
//            collision_cnt (saturating).
module spi_share_arbiter
   import spi_share_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int GUARD_CYCLES  = 8,
   parameter bit HOST_PRIORITY = 1'b1
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ss2_n,
   input  logic                  ss3_n,
   input  logic                  conf_data0,
   input  logic                  ss4_n,
   input  logic                  sck_host,
   input  logic                  sck_sd,
   input  logic                  miso_core,
   input  logic                  miso_sd,
   output logic                  sck_out,
   output logic                  miso_out,
   output logic                  miso_oe,
   output logic [1:0]            owner,
   output logic                  collision,
   output logic [COLL_CNT_W-1:0] collision_cnt,
   input  logic                  clr_stats
);

   // Bit order: ss2_n, ss3_n, conf_data0, ss4_n, sck_host, sck_sd.
   // Reset values are the inactive levels (selects off, SCKs low).
   localparam int             NSYNC    = 6;
   localparam logic [NSYNC-1:0] SYNC_RST = 6'b00_1011;

   logic [NSYNC-1:0] raw_vec;
   logic [NSYNC-1:0] sync_vec;

   assign raw_vec = {sck_sd, sck_host, ss4_n, conf_data0, ss3_n, ss2_n};

   generate
      for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
         sync_bit #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (SYNC_RST[gi])
         ) u_sync (
            .clk_i (clk_sys),
            .rst_i (reset),
            .d_i   (raw_vec[gi]),
            .q_o   (sync_vec[gi])
         );
      end
   endgenerate

   logic host_req, sd_req, sck_h_s, sck_d_s;
   assign host_req = ~sync_vec[0] | ~sync_vec[1] | sync_vec[2];
   assign sd_req   = ~sync_vec[3];
   assign sck_h_s  = sync_vec[4];
   assign sck_d_s  = sync_vec[5];

   state_t                state_q;
   owner_t                owner_q;
   logic                  g_host_q, g_sd_q;
   logic [GUARD_W-1:0]    guard_q;
   logic                  host_req_q, sd_req_q;
   logic                  collision_q;
   logic [COLL_CNT_W-1:0] coll_cnt_q;

   logic pick_host, pick_sd, coll_hit;

   // Arbitration winner when leaving IDLE; a tie goes to the priority side.
   assign pick_host = host_req & (~sd_req | HOST_PRIORITY);
   assign pick_sd   = sd_req & (~host_req | ~HOST_PRIORITY);

   // Only a fresh request from the non-owning side counts as a collision.
   assign coll_hit = ((state_q == GRANT_HOST) & sd_req & ~sd_req_q) |
                     ((state_q == GRANT_SD) & host_req & ~host_req_q);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_NONE;
         g_host_q    <= 1'b0;
         g_sd_q      <= 1'b0;
         guard_q     <= '0;
         host_req_q  <= 1'b0;
         sd_req_q    <= 1'b0;
         collision_q <= 1'b0;
         coll_cnt_q  <= '0;
      end else begin
         host_req_q <= host_req;
         sd_req_q   <= sd_req;

         // A grant is dropped only while its SCK is low so sck_out cannot
         // be cut mid-pulse; it may therefore linger into GUARD.
         if (state_q != GRANT_HOST && !sck_h_s) g_host_q <= 1'b0;
         if (state_q != GRANT_SD && !sck_d_s)   g_sd_q   <= 1'b0;

         case (state_q)
            IDLE: begin
               if (pick_host) begin
                  if (!sck_h_s) begin
                     state_q  <= GRANT_HOST;
                     owner_q  <= OWN_HOST;
                     g_host_q <= 1'b1;
                  end
               end else if (pick_sd) begin
                  if (!sck_d_s) begin
                     state_q <= GRANT_SD;
                     owner_q <= OWN_SD;
                     g_sd_q  <= 1'b1;
                  end
               end
            end
            GRANT_HOST: begin
               if (!host_req) begin
                  state_q <= GUARD;
                  guard_q <= GUARD_W'(GUARD_CYCLES);
               end
            end
            GRANT_SD: begin
               if (!sd_req) begin
                  state_q <= GUARD;
                  guard_q <= GUARD_W'(GUARD_CYCLES);
               end
            end
            GUARD: begin
               // owner keeps the previous side until the guard expires.
               if (guard_q <= 1 && !sck_h_s && !sck_d_s) begin
                  state_q <= IDLE;
                  owner_q <= OWN_NONE;
                  guard_q <= '0;
               end else if (guard_q != 0) begin
                  guard_q <= guard_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (clr_stats) begin
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
         end else if (coll_hit) begin
            collision_q <= 1'b1;
            coll_cnt_q  <= sat_inc(coll_cnt_q);
         end
      end
   end

   assign owner         = owner_q;
   assign collision     = collision_q;
   assign collision_cnt = coll_cnt_q;
   assign sck_out       = (sck_host & g_host_q) | (sck_sd & g_sd_q);

   always_comb begin
      miso_out = 1'b0;
      miso_oe  = 1'b0;
      case (state_q)
         GRANT_HOST: begin
            miso_out = miso_core;
            miso_oe  = ~ss2_n | ~ss3_n | conf_data0;
         end
         GRANT_SD: begin
            miso_out = miso_sd;
            miso_oe  = 1'b1;
         end
         default: begin
            miso_out = 1'b0;
            miso_oe  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_share_arbiter.sv
module tb_spi_share_arbiter;

   localparam int S         = 2;
   localparam int G         = 8;
   localparam int GRANT_LAT = S + 1;
   localparam int REL_LAT   = S + 1 + G;

   logic clk_sys = 1'b0;
   logic reset = 1'b1;
   logic ss2_n = 1'b1, ss3_n = 1'b1, conf_data0 = 1'b0, ss4_n = 1'b1;
   logic sck_host = 1'b0, sck_sd = 1'b0;
   logic miso_core = 1'b0, miso_sd = 1'b0;
   logic clr_stats = 1'b0;
   logic sck_out, miso_out, miso_oe, collision;
   logic [1:0] owner;
   logic [7:0] collision_cnt;

   int n_pass = 0;
   int n_total = 0;
   int coll_model = 0;

   always #5 clk_sys = ~clk_sys;

   spi_share_arbiter #(
      .SYNC_STAGES   (S),
      .GUARD_CYCLES  (G),
      .HOST_PRIORITY (1'b1)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .ss2_n         (ss2_n),
      .ss3_n         (ss3_n),
      .conf_data0    (conf_data0),
      .ss4_n         (ss4_n),
      .sck_host      (sck_host),
      .sck_sd        (sck_sd),
      .miso_core     (miso_core),
      .miso_sd       (miso_sd),
      .sck_out       (sck_out),
      .miso_out      (miso_out),
      .miso_oe       (miso_oe),
      .owner         (owner),
      .collision     (collision),
      .collision_cnt (collision_cnt),
      .clr_stats     (clr_stats)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // side: 0 ss2, 1 ss3, 2 conf_data0, 3 ss4
   task automatic set_sel(input int side, input bit active);
      case (side)
         0: ss2_n = ~active;
         1: ss3_n = ~active;
         2: conf_data0 = active;
         default: ss4_n = ~active;
      endcase
   endtask

   task automatic pulse_sel(input int side);
      set_sel(side, 1'b1);
      tick(3);
      set_sel(side, 1'b0);
      tick(3);
   endtask

   task automatic model_coll();
      coll_model = (coll_model >= 255) ? 255 : coll_model + 1;
   endtask

   initial begin
      bit b;
      int side, nbits, ncoll, exp_own;

      // ---------------- reset state
      tick(2);
      chk("rst_owner", owner, 0);
      chk("rst_sck_out", sck_out, 0);
      chk("rst_miso_oe", miso_oe, 0);
      chk("rst_miso_out", miso_out, 0);
      chk("rst_collision", collision, 0);
      chk("rst_coll_cnt", collision_cnt, 0);
      reset = 1'b0;
      tick(1);

      // ---------------- host only
      ss2_n = 1'b0;
      tick(GRANT_LAT - 1);
      chk("host_lat_early", owner, 0);
      tick(1);
      chk("host_grant", owner, 1);
      for (int i = 0; i < 16; i++) begin
         b = 1'($urandom_range(0, 1));
         miso_core = b;
         sck_host = 1'b1;
         #1;
         chk("host_sck_hi", sck_out, 1);
         chk("host_miso", miso_out, b);
         chk("host_oe", miso_oe, 1);
         tick(1);
         sck_host = 1'b0;
         #1;
         chk("host_sck_lo", sck_out, 0);
         tick(1);
      end
      ss2_n = 1'b1;
      tick(REL_LAT - 1);
      chk("host_guard_hold", owner, 1);
      chk("host_guard_oe", miso_oe, 0);
      tick(1);
      chk("host_release", owner, 0);
      $display("txn host_only: 16 bits, released");

      // ---------------- simultaneous requests, host priority
      ss3_n = 1'b0;
      ss4_n = 1'b0;
      tick(GRANT_LAT);
      chk("simul_owner", owner, 1);
      tick(4);
      chk("simul_no_coll", collision, 0);
      ss3_n = 1'b1;
      for (int k = 1; k <= REL_LAT + 1; k++) begin
         tick(1);
         if (k < REL_LAT + 1) begin
            sck_host = (k == 5 || k == 7);
            #1;
            chk("handover_sck", sck_out, 0);
         end
         if (k == REL_LAT) chk("handover_idle", owner, 0);
      end
      chk("handover_sd", owner, 2);
      chk("handover_sd_oe", miso_oe, 1);
      ss4_n = 1'b1;
      tick(REL_LAT);
      chk("sd_release", owner, 0);
      $display("txn simultaneous: host first, then SD after guard");

      // ---------------- collisions while SD owns
      ss4_n = 1'b0;
      tick(GRANT_LAT);
      chk("coll_sd_owner", owner, 2);
      for (int i = 0; i < 3; i++) begin
         pulse_sel(2);
         model_coll();
      end
      tick(2);
      chk("coll_flag", collision, 1);
      chk("coll_cnt3", collision_cnt, 32'(coll_model));
      clr_stats = 1'b1;
      tick(1);
      clr_stats = 1'b0;
      coll_model = 0;
      chk("clr_flag", collision, 0);
      chk("clr_cnt", collision_cnt, 0);
      // increment lands on the same edge as clr_stats: clear wins
      conf_data0 = 1'b1;
      tick(S);
      clr_stats = 1'b1;
      tick(1);
      clr_stats = 1'b0;
      chk("clr_prio_cnt", collision_cnt, 0);
      chk("clr_prio_flag", collision, 0);
      conf_data0 = 1'b0;
      tick(3);
      $display("txn collision: 3 pulses counted, cleared");

      // ---------------- saturation
      for (int i = 0; i < 300; i++) begin
         pulse_sel(0);
         model_coll();
      end
      tick(2);
      chk("sat_cnt", collision_cnt, 32'(coll_model));
      chk("sat_flag", collision, 1);
      clr_stats = 1'b1;
      tick(1);
      clr_stats = 1'b0;
      coll_model = 0;
      chk("sat_clr", collision_cnt, 0);
      ss4_n = 1'b1;
      tick(REL_LAT);
      chk("sat_release", owner, 0);
      $display("txn saturation: 300 collisions");

      // ---------------- SCK high at request
      sck_sd = 1'b1;
      ss4_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("sckhi_no_pulse", sck_out, 0);
      end
      chk("sckhi_wait", owner, 0);
      sck_sd = 1'b0;
      tick(GRANT_LAT - 1);
      chk("sckhi_early", owner, 0);
      tick(1);
      chk("sckhi_grant", owner, 2);
      chk("sckhi_sck", sck_out, 0);
      $display("txn sck_high_request: granted after SCK fell");

      // ---------------- reset mid-transfer
      for (int i = 0; i < 3; i++) begin
         sck_sd = 1'b1;
         tick(1);
         sck_sd = 1'b0;
         tick(1);
      end
      sck_sd = 1'b1;
      miso_sd = 1'b1;
      #1;
      chk("pre_rst_sck", sck_out, 1);
      chk("pre_rst_miso", miso_out, 1);
      reset = 1'b1;
      #1;
      chk("midrst_sck", sck_out, 0);
      chk("midrst_oe", miso_oe, 0);
      chk("midrst_owner", owner, 0);
      chk("midrst_miso", miso_out, 0);
      sck_sd = 1'b0;
      miso_sd = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(GRANT_LAT - 1);
      chk("postrst_early", owner, 0);
      tick(1);
      chk("postrst_grant", owner, 2);
      ss4_n = 1'b1;
      tick(REL_LAT);
      chk("postrst_release", owner, 0);
      $display("txn reset_mid_transfer: re-granted after reset");

      // ---------------- randomised transactions vs reference model
      for (int t = 0; t < 12; t++) begin
         side = $urandom_range(0, 3);
         nbits = $urandom_range(1, 16);
         ncoll = $urandom_range(0, 2);
         exp_own = (side == 3) ? 2 : 1;
         set_sel(side, 1'b1);
         tick(GRANT_LAT);
         chk("rnd_owner", owner, 32'(exp_own));
         for (int i = 0; i < nbits; i++) begin
            b = 1'($urandom_range(0, 1));
            if (side == 3) begin
               miso_sd = b;
               miso_core = ~b;
               sck_sd = 1'b1;
            end else begin
               miso_core = b;
               miso_sd = ~b;
               sck_host = 1'b1;
            end
            #1;
            chk("rnd_sck_hi", sck_out, 1);
            chk("rnd_miso", miso_out, b);
            chk("rnd_oe", miso_oe, 1);
            tick(1);
            sck_sd = 1'b0;
            sck_host = 1'b0;
            #1;
            chk("rnd_sck_lo", sck_out, 0);
            tick(1);
            if (i == 0) begin
               for (int c = 0; c < ncoll; c++) begin
                  pulse_sel((side == 3) ? int'($urandom_range(0, 2)) : 3);
                  model_coll();
               end
            end
         end
         set_sel(side, 1'b0);
         tick(REL_LAT);
         chk("rnd_release", owner, 0);
         chk("rnd_coll_cnt", collision_cnt, 32'(coll_model));
         chk("rnd_coll_flag", collision, (coll_model > 0) ? 1 : 0);
         $display("txn rnd %0d: side=%0d bits=%0d coll=%0d cnt=%0d", t, side, nbits, ncoll, collision_cnt);
         tick(2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
